// File: rtl/mem_16x8.sv
// ---------------------------------------------------------------------------
// mem_16x8 -- single-port synchronous scratch RAM, DEPTH words x DATA_WIDTH.
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   rst      in   asynchronous active-low reset; clears array and Dataout
//   wr       in   write enable, active high: mem[addr] <= Datain
//   rd       in   read enable, active high:  Dataout <= mem[addr]
//   addr     in   word address shared by read and write
//   Datain   in   write data
//   Dataout  out  registered read data, holds its value while rd=0
//
// Read latency is one cycle. When wr and rd hit the same address in the
// same cycle the read returns the previous contents (read-before-write);
// the new word is returned by the following read.
// ---------------------------------------------------------------------------
module mem_16x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16   // must equal 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] Datain,
    output logic [DATA_WIDTH-1:0] Dataout
);

    // Storage is built from resettable flops so that an asynchronous
    // reset can clear every word at once.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DEPTH-1:0]      wr_sel_d;

    // One-hot write select. Each word is gated by its own select bit, so an
    // unknown wr can at worst disturb the addressed word, never a neighbour.
    always_comb begin
        wr_sel_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel_d[i] = wr && (addr == ADDR_WIDTH'(i));
        end
    end

    // Read mux: only the registered Dataout sees the array, so no input has
    // a combinational path to the output.
    always_comb begin
        dout_d = dout_q;
        if (rd) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel_d[i]) begin
                    mem_q[i] <= Datain;
                end
            end
        end
    end

    // dout_d samples mem_q before this edge's write lands, which gives the
    // read-before-write behaviour for a same-address wr+rd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign Dataout = dout_q;

endmodule

// File: tb/tb_mem_16x8.sv
module tb_mem_16x8;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [3:0] addr;
  logic [7:0] Datain;
  logic [7:0] Dataout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: plain array of words plus the last read result.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_dout;
  logic [7:0] exp_q [$];

  mem_16x8 dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .Datain  (Datain),
    .Dataout (Dataout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    exp_dout = 8'h00;
  endtask

  // driver: apply one command for one rising edge, sample 1 ns after it
  task automatic cycle(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; addr = a; Datain = d;
    @(posedge clk);
    #1;
    if (rst) begin
      if (r) exp_dout = ref_mem[a];
      if (w) ref_mem[a] = d;
    end
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 4'h0; Datain = 8'h00;
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (Dataout !== 8'h00) begin
      n_fail++; $display("FAIL reset_now: Dataout=%h expected 00", Dataout);
    end
    // wr/rd ignored while reset held
    cycle(1'b1, 1'b1, 4'h3, 8'h5C);
    n_checks++;
    if (Dataout !== 8'h00) begin
      n_fail++; $display("FAIL reset_hold: Dataout=%h expected 00", Dataout);
    end
    @(negedge clk) rst = 1'b1;
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 1'b1, 4'(a), 8'h00);
      n_checks++;
      if (Dataout !== 8'h00) begin
        n_fail++; $display("FAIL reset_read a=%0d: Dataout=%h expected 00", a, Dataout);
      end
    end
  endtask

  task automatic test_write_read();
    cycle(1'b1, 1'b0, 4'h1, 8'hAA);
    cycle(1'b1, 1'b0, 4'h2, 8'hBB);
    cycle(1'b0, 1'b1, 4'h1, 8'h00);
    n_checks++;
    if (Dataout !== 8'hAA) begin
      n_fail++; $display("FAIL wr_rd_1: Dataout=%h expected AA", Dataout);
    end
    cycle(1'b0, 1'b1, 4'h2, 8'h00);
    n_checks++;
    if (Dataout !== 8'hBB) begin
      n_fail++; $display("FAIL wr_rd_2: Dataout=%h expected BB", Dataout);
    end
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b0, 4'h2, 8'h00);
    n_checks++;
    if (Dataout !== 8'hBB) begin
      n_fail++; $display("FAIL hold: Dataout=%h expected BB", Dataout);
    end
    cycle(1'b0, 1'b0, 4'h1, 8'h77);
    n_checks++;
    if (Dataout !== 8'hBB) begin
      n_fail++; $display("FAIL hold_addr_change: Dataout=%h expected BB", Dataout);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b0, 4'h5, 8'h11);
    cycle(1'b1, 1'b1, 4'h5, 8'h22);
    n_checks++;
    if (Dataout !== 8'h11) begin
      n_fail++; $display("FAIL rw_old: Dataout=%h expected 11", Dataout);
    end
    cycle(1'b0, 1'b1, 4'h5, 8'h00);
    n_checks++;
    if (Dataout !== 8'h22) begin
      n_fail++; $display("FAIL rw_new: Dataout=%h expected 22", Dataout);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b1, 4'h2, 8'h00);
    n_checks++;
    if (Dataout !== 8'hBB) begin
      n_fail++; $display("FAIL mid_pre: Dataout=%h expected BB", Dataout);
    end
    #2 rst = 1'b0;   // between edges
    model_clear();
    #1;
    n_checks++;
    if (Dataout !== 8'h00) begin
      n_fail++; $display("FAIL mid_async: Dataout=%h expected 00", Dataout);
    end
    @(negedge clk) rst = 1'b1;
    cycle(1'b0, 1'b1, 4'h1, 8'h00);
    n_checks++;
    if (Dataout !== 8'h00) begin
      n_fail++; $display("FAIL mid_rd1: Dataout=%h expected 00", Dataout);
    end
    cycle(1'b0, 1'b1, 4'h2, 8'h00);
    n_checks++;
    if (Dataout !== 8'h00) begin
      n_fail++; $display("FAIL mid_rd2: Dataout=%h expected 00", Dataout);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] e;
    for (int a = 0; a < 16; a++) cycle(1'b1, 1'b0, 4'(a), 8'(a) ^ 8'hA5);
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 1'b1, 4'(a), 8'h00);
      e = 8'(a) ^ 8'hA5;
      n_checks++;
      if (Dataout !== e) begin
        n_fail++; $display("FAIL sweep a=%0d: Dataout=%h expected %h", a, Dataout, e);
      end
    end
  endtask

  task automatic test_random();
    logic       w, r;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      if (r) exp_q.push_back(ref_mem[a]);
      cycle(w, r, a, d);
      if (r) e = exp_q.pop_front();
      else   e = exp_dout;   // idle: last read value held
      n_checks++;
      if (Dataout !== e) begin
        n_fail++;
        $display("FAIL random n=%0d w=%b r=%b a=%0d: Dataout=%h expected %h", n, w, r, a, Dataout, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_simultaneous();
    test_mid_reset();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_16x8.md
Name: mem_16x8

Overview:
Single-port synchronous RAM, 16 words x 8 bits, used as a small scratch/register store.
- Write and read commands are sampled on the rising clock edge.
- Read data comes out through a registered output that holds its value between reads.
- An asynchronous active-low reset clears the whole array and the output register.

Parameters:
DATA_WIDTH, 8, width of each word and of Datain/Dataout
ADDR_WIDTH, 4, address width
DEPTH, 16, number of words (must equal 2**ADDR_WIDTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
wr  input  1  write enable, active high
rd  input  1  read enable, active high
addr  input  ADDR_WIDTH  word address for read and write
Datain  input  DATA_WIDTH  write data
Dataout  output  DATA_WIDTH  registered read data

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst).
- Reset assertion (rst=0), at any time, independent of clk:
  - all DEPTH words clear to 0 immediately;
  - Dataout clears to 0 immediately.
  - Both stay 0 while rst=0.
  - wr and rd are ignored during reset.
- Reset release: synchronous use resumes from the first rising clk edge with rst=1.
- Write: at a rising edge with wr=1, mem[addr] <= Datain. Visible to a read at the next edge or later.
- Read:
  - At a rising edge with rd=1, Dataout <= mem[addr].
  - Latency is 1 cycle: Dataout is valid after the edge that sampled rd.
- Idle (rd=0): Dataout holds its last value. It does not return to 0 or high-Z.
- wr=1 and rd=1 in the same cycle:
  - both operations are performed;
  - read-before-write: Dataout gets the OLD contents of mem[addr];
  - the new Datain is stored and is returned by the next read.
- Address: full 4-bit range 0..15 is valid; no out-of-range case exists.
- No combinational path from any input to Dataout, except the asynchronous reset.
- X handling: an X on wr or rd at a clock edge must not corrupt locations other than the addressed one. Simulation assertions are optional.

Test Plan:
1. Reset: rst=0 for one cycle, then release; read addr 0..15 in turn -> Dataout=00 for every address; Dataout=00 while rst=0.
2. Write then read:
   - write AA @1, then write BB @2;
   - rd @1 -> Dataout=AA one edge later;
   - rd @2 -> Dataout=BB one edge later.
3. Hold: after the read of @2 (Dataout=BB), drive wr=0, rd=0, addr=2 for one cycle -> Dataout stays BB.
4. Simultaneous wr/rd:
   - write 11 @5;
   - then wr=1, rd=1, addr=5, Datain=22 -> Dataout=11 (old value);
   - next rd @5 -> Dataout=22.
5. Mid-operation reset: with Dataout=BB and locations holding data, drop rst asynchronously (between edges) -> Dataout=00 immediately; after release, rd @1 and @2 -> 00.
6. Full sweep: write value (addr XOR A5) to all 16 addresses, read back all -> each matches and no aliasing (addr 0 and 15 included).
